// File: rtl/audio_i2s_pkg.sv
// Shared I2S definitions for the codec ADC receiver and DAC driver.
// Slot geometry, channel encoding and receiver sync states.
package audio_i2s_pkg;

  localparam int unsigned I2S_SLOT_BITS = 32;
  localparam int unsigned I2S_CNT_W     = 5;
  localparam logic [I2S_CNT_W-1:0] I2S_CNT_MAX = I2S_CNT_W'(I2S_SLOT_BITS - 1);

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } i2s_chan_t;

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_SYNC   = 1'b1
  } i2s_rx_state_t;

  // Slot bit counter increment that holds at the last slot index
  function automatic logic [I2S_CNT_W-1:0] cnt_sat_inc(input logic [I2S_CNT_W-1:0] c);
    return (c == I2S_CNT_MAX) ? c : c + I2S_CNT_W'(1);
  endfunction

endpackage

// File: rtl/audio_i2s_receiver_if.sv
// Pin and sample bus of the I2S receiver: serial ADC pins in, stereo samples out.
interface audio_i2s_receiver_if #(
  parameter int unsigned AUD_BIT_DEPTH = 24
);

  logic                     i2s_enable;
  logic                     iAUD_ADCLRCK;
  logic                     iAUD_ADCDAT;
  logic [AUD_BIT_DEPTH-1:0] o_lsound_in;
  logic [AUD_BIT_DEPTH-1:0] o_rsound_in;
  logic                     o_valid;
  logic                     o_frame_err;

  modport master (
    output i2s_enable, iAUD_ADCLRCK, iAUD_ADCDAT,
    input  o_lsound_in, o_rsound_in, o_valid, o_frame_err
  );

  modport slave (
    input  i2s_enable, iAUD_ADCLRCK, iAUD_ADCDAT,
    output o_lsound_in, o_rsound_in, o_valid, o_frame_err
  );

endinterface

// File: rtl/audio_i2s_rx_shifter.sv
// Slot bit counter and MSB-first shift register with left-align zero fill.
// The bit-count output exists only when AUD_I2S_RX_FRAME_CHECK_EN is defined.
module audio_i2s_rx_shifter
  import audio_i2s_pkg::*;
#(
  parameter int unsigned AUD_BIT_DEPTH = 24
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_lrck,
  input  logic                     i_dat,
  output logic                     o_edge_c,
  output logic                     o_lrck_dly,
  output logic [AUD_BIT_DEPTH-1:0] o_word_c
`ifdef AUD_I2S_RX_FRAME_CHECK_EN
  ,
  output logic [I2S_CNT_W:0]       o_bits_c
`endif
);

  localparam int unsigned NB_W = I2S_CNT_W + 1;
  localparam logic [NB_W-1:0] DEPTH_N = NB_W'(AUD_BIT_DEPTH);

  logic                     r_lrck_dly;
  logic [I2S_CNT_W-1:0]     r_bit_cnt;
  logic                     r_ovf;
  logic [AUD_BIT_DEPTH-1:0] r_shift;

  logic                     w_edge;
  logic                     w_take;
  logic [NB_W-1:0]          w_nbits;
  logic [AUD_BIT_DEPTH-1:0] w_shift_nxt;

  // r_ovf marks bits past a saturated counter so an over-long slot never shifts
  always_comb begin
    w_edge      = r_lrck_dly ^ i_lrck;
    w_take      = !r_ovf && ({1'b0, r_bit_cnt} < DEPTH_N);
    w_shift_nxt = w_take ? ((r_shift << 1) | AUD_BIT_DEPTH'(i_dat)) : r_shift;
    w_nbits     = w_take ? (NB_W'(r_bit_cnt) + NB_W'(1)) : DEPTH_N;
  end

  assign o_edge_c   = w_edge;
  assign o_lrck_dly = r_lrck_dly;
  assign o_word_c   = w_shift_nxt << (DEPTH_N - w_nbits);

`ifdef AUD_I2S_RX_FRAME_CHECK_EN
  assign o_bits_c = r_ovf ? NB_W'(I2S_SLOT_BITS + 1) : (NB_W'(r_bit_cnt) + NB_W'(1));
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lrck_dly <= 1'b0;
      r_bit_cnt  <= '0;
      r_ovf      <= 1'b0;
      r_shift    <= '0;
    end else begin
      r_lrck_dly <= i_lrck;
      if (i_clr || w_edge) begin
        r_bit_cnt <= '0;
        r_ovf     <= 1'b0;
        r_shift   <= '0;
      end else begin
        r_bit_cnt <= cnt_sat_inc(r_bit_cnt);
        r_ovf     <= r_ovf | (r_bit_cnt == I2S_CNT_MAX);
        r_shift   <= w_shift_nxt;
      end
    end
  end

endmodule

// File: rtl/audio_i2s_receiver.sv
// I2S ADC receiver: word sync, left/right pairing and registered stereo outputs.
// Define AUD_I2S_RX_FRAME_CHECK_EN to enable the 32-bit slot framing check.
module audio_i2s_receiver
  import audio_i2s_pkg::*;
#(
  parameter int unsigned AUD_BIT_DEPTH = 24
) (
  input  logic                 iAUDB_CLK,
  input  logic                 reset_reg_N,
  audio_i2s_receiver_if.slave  bus
);

  logic                     w_edge;
  logic                     w_lrck_dly;
  logic [AUD_BIT_DEPTH-1:0] w_word;
  i2s_chan_t                w_chan;

  i2s_rx_state_t            r_state;
  i2s_rx_state_t            w_state_nxt;
  logic [AUD_BIT_DEPTH-1:0] r_lsound;
  logic [AUD_BIT_DEPTH-1:0] r_rsound;
  logic [AUD_BIT_DEPTH-1:0] r_hold;
  logic                     r_valid;
  logic                     r_have_left;
  logic [AUD_BIT_DEPTH-1:0] w_lsound_nxt;
  logic [AUD_BIT_DEPTH-1:0] w_rsound_nxt;
  logic [AUD_BIT_DEPTH-1:0] w_hold_nxt;
  logic                     w_valid_nxt;
  logic                     w_have_left_nxt;
  logic                     w_capture;

`ifdef AUD_I2S_RX_FRAME_CHECK_EN
  logic [I2S_CNT_W:0]       w_bits;
`endif

  audio_i2s_rx_shifter #(
    .AUD_BIT_DEPTH (AUD_BIT_DEPTH)
  ) u_shifter (
    .i_clk      (iAUDB_CLK),
    .i_rst_n    (reset_reg_N),
    .i_clr      (!bus.i2s_enable),
    .i_lrck     (bus.iAUD_ADCLRCK),
    .i_dat      (bus.iAUD_ADCDAT),
    .o_edge_c   (w_edge),
    .o_lrck_dly (w_lrck_dly),
    .o_word_c   (w_word)
`ifdef AUD_I2S_RX_FRAME_CHECK_EN
    ,
    .o_bits_c   (w_bits)
`endif
  );

  assign w_chan = i2s_chan_t'(w_lrck_dly);

  // First edge after reset/enable only aligns; later edges complete a word
  always_comb begin
    w_state_nxt     = r_state;
    w_lsound_nxt    = r_lsound;
    w_rsound_nxt    = r_rsound;
    w_hold_nxt      = r_hold;
    w_valid_nxt     = 1'b0;
    w_have_left_nxt = r_have_left;
    w_capture       = 1'b0;
    if (!bus.i2s_enable) begin
      w_state_nxt     = ST_UNSYNC;
      w_have_left_nxt = 1'b0;
    end else if (w_edge) begin
      if (r_state == ST_UNSYNC) begin
        w_state_nxt = ST_SYNC;
      end else begin
        w_capture = 1'b1;
        if (w_chan == LEFT) begin
          w_hold_nxt      = w_word;
          w_have_left_nxt = 1'b1;
        end else begin
          if (r_have_left) begin
            w_lsound_nxt = r_hold;
            w_rsound_nxt = w_word;
            w_valid_nxt  = 1'b1;
          end
          w_have_left_nxt = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iAUDB_CLK) begin
    if (!reset_reg_N) begin
      r_state     <= ST_UNSYNC;
      r_lsound    <= '0;
      r_rsound    <= '0;
      r_hold      <= '0;
      r_valid     <= 1'b0;
      r_have_left <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lsound    <= w_lsound_nxt;
      r_rsound    <= w_rsound_nxt;
      r_hold      <= w_hold_nxt;
      r_valid     <= w_valid_nxt;
      r_have_left <= w_have_left_nxt;
    end
  end

  assign bus.o_lsound_in = r_lsound;
  assign bus.o_rsound_in = r_rsound;
  assign bus.o_valid     = r_valid;

`ifdef AUD_I2S_RX_FRAME_CHECK_EN
  localparam int unsigned NB_W = I2S_CNT_W + 1;

  logic r_frame_err;
  logic r_left_ok;
  logic w_frame_err_nxt;
  logic w_left_ok_nxt;
  logic w_slot_ok;

  // Error is sticky until a strobe whose left and right slots were both 32 bits
  always_comb begin
    w_slot_ok       = (w_bits == NB_W'(I2S_SLOT_BITS));
    w_frame_err_nxt = r_frame_err;
    w_left_ok_nxt   = r_left_ok;
    if (w_capture) begin
      if (w_chan == LEFT) begin
        w_left_ok_nxt = w_slot_ok;
        if (!w_slot_ok) begin
          w_frame_err_nxt = 1'b1;
        end
      end else if (r_have_left) begin
        w_frame_err_nxt = !(r_left_ok && w_slot_ok);
      end else if (!w_slot_ok) begin
        w_frame_err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge iAUDB_CLK) begin
    if (!reset_reg_N) begin
      r_frame_err <= 1'b0;
      r_left_ok   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err_nxt;
      r_left_ok   <= w_left_ok_nxt;
    end
  end

  assign bus.o_frame_err = r_frame_err;
`else
  assign bus.o_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_audio_i2s_receiver.sv
// Self-checking bench: 24-bit and 16-bit receivers share one serial stream,
// checked every BCLK against a word-level reference model.
module tb_audio_i2s_receiver;

`ifdef AUD_I2S_RX_FRAME_CHECK_EN
  localparam bit FCHK = 1'b1;
`else
  localparam bit FCHK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic en;

  audio_i2s_receiver_if #(.AUD_BIT_DEPTH(24)) bus24 ();
  audio_i2s_receiver_if #(.AUD_BIT_DEPTH(16)) bus16 ();

  audio_i2s_receiver #(.AUD_BIT_DEPTH(24)) u_dut24 (
    .iAUDB_CLK   (clk),
    .reset_reg_N (rst_n),
    .bus         (bus24)
  );

  audio_i2s_receiver #(.AUD_BIT_DEPTH(16)) u_dut16 (
    .iAUDB_CLK   (clk),
    .reset_reg_N (rst_n),
    .bus         (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index 0 = 24-bit DUT, 1 = 16-bit DUT
  int          dep [2] = '{24, 16};
  logic [31:0] m_l [2];
  logic [31:0] m_r [2];
  logic [31:0] m_hold [2];
  bit          m_v [2];
  bit          m_have [2];
  bit          m_lok [2];
  bit          m_err [2];
  bit          m_sync;
  bit          m_prev;
  logic [31:0] rec_data;
  int          rec_len;
  bit          pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Top min(len, depth) slot bits, zero-filled below, as a depth-bit sample
  function automatic logic [31:0] wordval(input logic [31:0] data, input int len, input int depth);
    int n;
    logic [31:0] mask;
    n = (len < depth) ? len : depth;
    mask = (n >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> n);
    return (data & mask) >> (32 - depth);
  endfunction

  task automatic complete_word(input int i, input bit lvl, input logic [31:0] data, input int len);
    logic [31:0] val;
    bit ok;
    val = wordval(data, len, dep[i]);
    ok  = (len == 32);
    if (!lvl) begin
      m_hold[i] = val;
      m_have[i] = 1'b1;
      m_lok[i]  = ok;
      if (FCHK && !ok) m_err[i] = 1'b1;
    end else begin
      if (m_have[i]) begin
        m_l[i] = m_hold[i];
        m_r[i] = val;
        m_v[i] = 1'b1;
        if (FCHK) m_err[i] = !(m_lok[i] && ok);
      end else if (FCHK && !ok) begin
        m_err[i] = 1'b1;
      end
      m_have[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit lv);
    bit edge_seen;
    edge_seen = m_prev ^ lv;
    for (int i = 0; i < 2; i++) m_v[i] = 1'b0;
    if (!rst_n) begin
      m_sync = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_l[i] = '0; m_r[i] = '0; m_have[i] = 1'b0; m_err[i] = 1'b0; m_lok[i] = 1'b0;
      end
      m_prev = 1'b0;
    end else begin
      if (!en) begin
        m_sync = 1'b0;
        for (int i = 0; i < 2; i++) m_have[i] = 1'b0;
      end else if (edge_seen) begin
        if (!m_sync) m_sync = 1'b1;
        else for (int i = 0; i < 2; i++) complete_word(i, m_prev, rec_data, rec_len);
      end
      m_prev = lv;
    end
  endtask

  task automatic check_outputs();
    chk("d24_valid", 32'(bus24.o_valid),     32'(m_v[0]));
    chk("d24_left",  32'(bus24.o_lsound_in), m_l[0]);
    chk("d24_right", 32'(bus24.o_rsound_in), m_r[0]);
    chk("d24_ferr",  32'(bus24.o_frame_err), 32'(m_err[0]));
    chk("d16_valid", 32'(bus16.o_valid),     32'(m_v[1]));
    chk("d16_left",  32'(bus16.o_lsound_in), m_l[1]);
    chk("d16_right", 32'(bus16.o_rsound_in), m_r[1]);
    chk("d16_ferr",  32'(bus16.o_frame_err), 32'(m_err[1]));
  endtask

  // One word at LRCK level lv; its MSB follows one BCLK after the level change
  task automatic send_word(input bit lv, input logic [31:0] data, input int len,
                           input int rst_until, input int dis_lo, input int dis_hi);
    for (int k = 0; k < len; k++) begin
      bit d;
      if (k == 0) d = pend;
      else if (k - 1 < 32) d = data[31 - (k - 1)];
      else d = 1'b0;
      @(negedge clk);
      rst_n = (k >= rst_until);
      en    = !(k >= dis_lo && k < dis_hi);
      bus24.i2s_enable = en;   bus16.i2s_enable = en;
      bus24.iAUD_ADCLRCK = lv; bus16.iAUD_ADCLRCK = lv;
      bus24.iAUD_ADCDAT = d;   bus16.iAUD_ADCDAT = d;
      model_step(lv);
      if (k == 0) begin
        rec_data = data;
        rec_len  = len;
      end
      @(posedge clk);
      #1;
      check_outputs();
    end
    pend = (len - 1 < 32) ? data[31 - (len - 1)] : 1'b0;
  endtask

  task automatic w(input bit lv, input logic [31:0] data, input int len);
    send_word(lv, data, len, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit lv;
    rst_n = 1'b0; en = 1'b1; pend = 1'b0;
    m_prev = 1'b0; m_sync = 1'b0; rec_data = '0; rec_len = 32;
    for (int i = 0; i < 2; i++) begin
      m_l[i] = '0; m_r[i] = '0; m_hold[i] = '0;
      m_v[i] = 1'b0; m_have[i] = 1'b0; m_lok[i] = 1'b0; m_err[i] = 1'b0;
    end
    bus24.i2s_enable = 1'b1; bus16.i2s_enable = 1'b1;
    bus24.iAUD_ADCLRCK = 1'b0; bus16.iAUD_ADCLRCK = 1'b0;
    bus24.iAUD_ADCDAT = 1'b0; bus16.iAUD_ADCDAT = 1'b0;

    send_word(1'b0, 32'h0, 4, 4, 0, 0);
    chk("rst_left",  32'(bus24.o_lsound_in), 32'h0);
    chk("rst_right", 32'(bus24.o_rsound_in), 32'h0);
    chk("rst_valid", 32'(bus24.o_valid), 32'h0);
    chk("rst_ferr",  32'(bus24.o_frame_err), 32'h0);

    // Nominal frames, first edge discarded
    w(1'b1, 32'hDEADBEEF, 32);
    w(1'b0, 32'h12345600, 32); w(1'b1, 32'hABCDEF00, 32);
    w(1'b0, 32'h12345600, 32); w(1'b1, 32'hABCDEF00, 32);
    w(1'b0, 32'h8001A5A5, 32);
    chk("nom_l24", 32'(bus24.o_lsound_in), 32'h123456);
    chk("nom_r24", 32'(bus24.o_rsound_in), 32'hABCDEF);
    chk("nom_l16", 32'(bus16.o_lsound_in), 32'h1234);
    chk("nom_r16", 32'(bus16.o_rsound_in), 32'hABCD);

    // Trailing slot bits past 16 ignored
    w(1'b1, 32'h7FFF5A5A, 32);
    w(1'b0, 32'hFFFFF000, 20);
    chk("d16_l", 32'(bus16.o_lsound_in), 32'h8001);
    chk("d16_r", 32'(bus16.o_rsound_in), 32'h7FFF);
    chk("d16_l24", 32'(bus24.o_lsound_in), 32'h8001A5);

    // Short 20-bit left slot, zero-filled
    w(1'b1, 32'h00000100, 32);
    w(1'b0, 32'h13579B00, 32);
    chk("short_l24", 32'(bus24.o_lsound_in), 32'hFFFFF0);
    chk("short_l16", 32'(bus16.o_lsound_in), 32'hFFFF);
    chk("short_ferr", 32'(bus24.o_frame_err), 32'(FCHK));
    w(1'b1, 32'h2468AC00, 32);
    w(1'b0, 32'h0F0F0F00, 32);
    chk("clean_ferr", 32'(bus24.o_frame_err), 32'h0);
    chk("clean_l24", 32'(bus24.o_lsound_in), 32'h13579B);

    // Reset released mid-right-word
    send_word(1'b1, 32'h77777700, 32, 12, 0, 0);
    w(1'b0, 32'h11111100, 32); w(1'b1, 32'h22222200, 32);
    w(1'b0, 32'h33333300, 32);
    chk("rstmid_l", 32'(bus24.o_lsound_in), 32'h111111);
    chk("rstmid_r", 32'(bus24.o_rsound_in), 32'h222222);

    // Enable dropped for 10 BCLK mid-left-word
    w(1'b1, 32'h44444400, 32);
    send_word(1'b0, 32'h55555500, 32, 0, 5, 15);
    chk("dis_hold_l", 32'(bus24.o_lsound_in), 32'h333333);
    chk("dis_hold_r", 32'(bus24.o_rsound_in), 32'h444444);
    w(1'b1, 32'h66666600, 32); w(1'b0, 32'h77777700, 32);
    w(1'b1, 32'h88888800, 32); w(1'b0, 32'h99999900, 32);
    chk("reen_l", 32'(bus24.o_lsound_in), 32'h777777);
    chk("reen_r", 32'(bus24.o_rsound_in), 32'h888888);

    // First captured word is a right word with no left
    send_word(1'b0, 32'h0, 6, 6, 0, 0);
    w(1'b1, 32'hAAAAAA00, 32); w(1'b0, 32'hBBBBBB00, 32);
    w(1'b1, 32'hCCCCCC00, 32); w(1'b0, 32'hDDDDDD00, 32);
    chk("noleft_l", 32'(bus24.o_lsound_in), 32'hBBBBBB);
    chk("noleft_r", 32'(bus24.o_rsound_in), 32'hCCCCCC);

    // Randomised data and occasional short/long slots
    lv = 1'b1;
    for (int n = 0; n < 80; n++) begin
      int len;
      len = ($urandom_range(0, 9) < 7) ? 32 : int'($urandom_range(2, 40));
      w(lv, $urandom, len);
      lv = ~lv;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
